// File: rtl/quad_pwm_cfg_scheduler_pkg.sv
// Shared definitions for the quad PWM configuration scheduler:
// register offsets (relative to BASE_ADDR, low 5 bits), CTRL/STATUS bit
// indices, the commit FSM state encoding and a byte-lane merge helper.
package quad_pwm_cfg_scheduler_pkg;

    localparam logic [4:0] OFF_CTRL   = 5'h00;
    localparam logic [4:0] OFF_PERIOD = 5'h04;
    localparam logic [4:0] OFF_DUTY0  = 5'h08;
    localparam logic [4:0] OFF_DUTY1  = 5'h0C;
    localparam logic [4:0] OFF_DUTY2  = 5'h10;
    localparam logic [4:0] OFF_DUTY3  = 5'h14;
    localparam logic [4:0] OFF_STATUS = 5'h18;
    localparam logic [4:0] OFF_IRQ_EN = 5'h1C;

    localparam int CTRL_COMMIT    = 0;
    localparam int CTRL_FAULT_CLR = 1;

    localparam int STAT_PENDING = 0;
    localparam int STAT_FAULT   = 1;
    localparam int STAT_DONE    = 2;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } commit_state_t;

    // Replace only the byte lanes selected by sel.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] wr_val,
                                               input logic [3:0]  sel);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{sel[b]}};
        end
        return (old_val & ~m) | (wr_val & m);
    endfunction

endpackage

// File: rtl/quad_pwm_commit_fsm.sv
// Commit scheduler: IDLE/PENDING state machine.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   commit_req    one-cycle pulse: COMMIT=1 written this cycle
//   period_end    PWM counter wrap strobe from the datapath
//   dp_idle       all effective channel enables are 0
//   pending       high while a commit is waiting
//   commit_stb    one-cycle pulse; the register file commits on this edge
module quad_pwm_commit_fsm
    import quad_pwm_cfg_scheduler_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic commit_req,
    input  logic period_end,
    input  logic dp_idle,
    output logic pending,
    output logic commit_stb
);

    commit_state_t state, state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // period_end is only looked at once PENDING, so a strobe coinciding
    // with the COMMIT write is deliberately ignored. Further COMMIT
    // writes while PENDING fall through unchanged.
    always_comb begin
        state_nxt  = state;
        commit_stb = 1'b0;
        pending    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (commit_req) begin
                    state_nxt = ST_PENDING;
                end
            end
            ST_PENDING: begin
                pending = 1'b1;
                if (period_end || dp_idle) begin
                    commit_stb = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/quad_pwm_cfg_scheduler.sv
// Wishbone configuration controller for the quad PWM FET driver.
// Shadow period/duty/enable registers are committed atomically to the
// active outputs only at a PWM period boundary (or immediately when the
// datapath is idle). Includes a fault latch that masks enables and
// registered interrupt outputs.
// Ports:
//   wb_clk_i, wb_rst_i      clock, asynchronous active-high reset
//   wbs_*                   wishbone slave (stb/cyc/we/sel/dat/adr in, ack/dat out)
//   period_end_i            PWM wrap strobe
//   fault_i                 synchronised FET fault level
//   cfg_period_o            active period
//   cfg_duty_o              active duties, channel n at [n*WIDTH +: WIDTH]
//   cfg_en_o                active enables masked by fault (combinational)
//   irq_o                   {0, fault irq, commit_done irq}, registered
module quad_pwm_cfg_scheduler
    import quad_pwm_cfg_scheduler_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          WIDTH     = 16
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_dat_i,
    input  logic [31:0]        wbs_adr_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    input  logic               period_end_i,
    input  logic               fault_i,
    output logic [WIDTH-1:0]   cfg_period_o,
    output logic [4*WIDTH-1:0] cfg_duty_o,
    output logic [3:0]         cfg_en_o,
    output logic [2:0]         irq_o
);

    function automatic logic [31:0] to_word(input logic [WIDTH-1:0] v);
        logic [31:0] w;
        w = '0;
        w[WIDTH-1:0] = v;
        return w;
    endfunction

    function automatic logic [WIDTH-1:0] merge_w(input logic [WIDTH-1:0] old_val,
                                                 input logic [31:0]      wr_val,
                                                 input logic [3:0]       sel);
        logic [31:0] t;
        t = byte_merge(to_word(old_val), wr_val, sel);
        return t[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] sat_duty(input logic [WIDTH-1:0] duty,
                                                  input logic [WIDTH-1:0] period);
        return (duty > period) ? period : duty;
    endfunction

    logic [WIDTH-1:0] shadow_period;
    logic [WIDTH-1:0] shadow_duty [4];
    logic [3:0]       shadow_en;
    logic [1:0]       irq_en;
    logic [WIDTH-1:0] active_period;
    logic [WIDTH-1:0] active_duty [4];
    logic [3:0]       active_en;
    logic             commit_done;
    logic             fault_latched;
    logic             ack_q;
    logic [31:0]      dat_q;
    logic [2:0]       irq_q;

    logic [31:0] offset;
    logic [4:0]  reg_sel;
    logic        in_range;
    logic        hit;
    logic        wr;
    logic        commit_req;
    logic        fault_clr;
    logic        done_clr;
    logic        pending;
    logic        commit_stb;
    logic [31:0] rdata;

    // Full 32-bit subtract so aliases such as BASE_ADDR+0x40 never decode.
    assign offset   = wbs_adr_i - BASE_ADDR;
    assign reg_sel  = offset[4:0];
    assign in_range = (offset[31:5] == '0) && (offset[1:0] == 2'b00);
    // Gating with ack_q forces the idle cycle after every ack.
    assign hit      = wbs_stb_i && wbs_cyc_i && in_range && !ack_q;
    assign wr       = hit && wbs_we_i;

    assign commit_req = wr && (reg_sel == OFF_CTRL)   && wbs_sel_i[0] && wbs_dat_i[CTRL_COMMIT];
    assign fault_clr  = wr && (reg_sel == OFF_CTRL)   && wbs_sel_i[0] && wbs_dat_i[CTRL_FAULT_CLR];
    assign done_clr   = wr && (reg_sel == OFF_STATUS) && wbs_sel_i[0] && wbs_dat_i[STAT_DONE];

    assign cfg_en_o = active_en & ~{4{fault_i | fault_latched}};

    quad_pwm_commit_fsm u_commit_fsm (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .commit_req (commit_req),
        .period_end (period_end_i),
        .dp_idle    (cfg_en_o == 4'b0000),
        .pending    (pending),
        .commit_stb (commit_stb)
    );

    always_comb begin
        rdata = '0;
        case (reg_sel)
            OFF_CTRL:   rdata[7:4] = shadow_en;
            OFF_PERIOD: rdata = to_word(shadow_period);
            OFF_DUTY0:  rdata = to_word(shadow_duty[0]);
            OFF_DUTY1:  rdata = to_word(shadow_duty[1]);
            OFF_DUTY2:  rdata = to_word(shadow_duty[2]);
            OFF_DUTY3:  rdata = to_word(shadow_duty[3]);
            OFF_STATUS: begin
                rdata[STAT_PENDING] = pending;
                rdata[STAT_FAULT]   = fault_latched;
                rdata[STAT_DONE]    = commit_done;
            end
            OFF_IRQ_EN: rdata[1:0] = irq_en;
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q         <= 1'b0;
            dat_q         <= '0;
            shadow_period <= '0;
            shadow_en     <= '0;
            irq_en        <= '0;
            active_period <= '0;
            active_en     <= '0;
            commit_done   <= 1'b0;
            fault_latched <= 1'b0;
            irq_q         <= '0;
            for (int i = 0; i < 4; i++) begin
                shadow_duty[i] <= '0;
                active_duty[i] <= '0;
            end
        end else begin
            ack_q <= hit;
            dat_q <= (hit && !wbs_we_i) ? rdata : '0;

            if (wr) begin
                case (reg_sel)
                    OFF_CTRL:   if (wbs_sel_i[0]) shadow_en <= wbs_dat_i[7:4];
                    OFF_PERIOD: shadow_period <= merge_w(shadow_period, wbs_dat_i, wbs_sel_i);
                    OFF_IRQ_EN: if (wbs_sel_i[0]) irq_en <= wbs_dat_i[1:0];
                    default: ;
                endcase
                for (int i = 0; i < 4; i++) begin
                    if (reg_sel == OFF_DUTY0 + 5'(4*i)) begin
                        shadow_duty[i] <= merge_w(shadow_duty[i], wbs_dat_i, wbs_sel_i);
                    end
                end
            end

            // Shadow values sampled here are those present before any
            // write landing on the same edge.
            if (commit_stb) begin
                active_period <= shadow_period;
                active_en     <= shadow_en;
                for (int i = 0; i < 4; i++) begin
                    active_duty[i] <= sat_duty(shadow_duty[i], shadow_period);
                end
            end

            // A commit on the same edge as a write-1-to-clear wins.
            if (commit_stb) begin
                commit_done <= 1'b1;
            end else if (done_clr) begin
                commit_done <= 1'b0;
            end

            if (fault_i) begin
                fault_latched <= 1'b1;
            end else if (fault_clr) begin
                fault_latched <= 1'b0;
            end

            irq_q <= {1'b0, fault_latched & irq_en[1], commit_done & irq_en[0]};
        end
    end

    always_comb begin
        cfg_duty_o = '0;
        for (int i = 0; i < 4; i++) begin
            cfg_duty_o[i*WIDTH +: WIDTH] = active_duty[i];
        end
    end

    assign cfg_period_o = active_period;
    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;
    assign irq_o        = irq_q;

endmodule

// File: tb/tb_quad_pwm_cfg_scheduler.sv
module tb_quad_pwm_cfg_scheduler;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          WIDTH = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               stb = 1'b0;
    logic               cyc = 1'b0;
    logic               we  = 1'b0;
    logic [3:0]         sel = 4'h0;
    logic [31:0]        wdat = '0;
    logic [31:0]        adr = '0;
    logic               ack;
    logic [31:0]        rdat;
    logic               period_end = 1'b0;
    logic               fault = 1'b0;
    logic [WIDTH-1:0]   cfg_period;
    logic [4*WIDTH-1:0] cfg_duty;
    logic [3:0]         cfg_en;
    logic [2:0]         irq;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    quad_pwm_cfg_scheduler #(
        .BASE_ADDR (BASE),
        .WIDTH     (WIDTH)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .wbs_stb_i    (stb),
        .wbs_cyc_i    (cyc),
        .wbs_we_i     (we),
        .wbs_sel_i    (sel),
        .wbs_dat_i    (wdat),
        .wbs_adr_i    (adr),
        .wbs_ack_o    (ack),
        .wbs_dat_o    (rdat),
        .period_end_i (period_end),
        .fault_i      (fault),
        .cfg_period_o (cfg_period),
        .cfg_duty_o   (cfg_duty),
        .cfg_en_o     (cfg_en),
        .irq_o        (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_xfer(input logic [31:0] off, input logic is_wr,
                            input logic [31:0] d, input logic [3:0] s,
                            output logic [31:0] q);
        bit seen;
        seen = 1'b0;
        q    = '0;
        @(posedge clk); #1;
        adr  = BASE + off;
        we   = is_wr;
        wdat = d;
        sel  = s;
        stb  = 1'b1;
        cyc  = 1'b1;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                seen = 1'b1;
                q    = rdat;
            end
        end
        stb = 1'b0;
        cyc = 1'b0;
        we  = 1'b0;
        if (!seen) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wb_wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] q;
        bus_xfer(off, 1'b1, d, s, q);
    endtask

    task automatic wb_rd(input logic [31:0] off, output logic [31:0] q);
        bus_xfer(off, 1'b0, 32'h0, 4'hF, q);
    endtask

    task automatic pulse_pe();
        @(posedge clk); #1;
        period_end = 1'b1;
        @(posedge clk); #1;
        period_end = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [31:0] q;
        logic [2:0]  ack_pat;
        int          ack_cnt;

        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // reset state
        chk("rst_period", 32'(cfg_period), 32'd0);
        chk("rst_duty_lo", cfg_duty[31:0], 32'd0);
        chk("rst_duty_hi", cfg_duty[63:32], 32'd0);
        chk("rst_en", 32'(cfg_en), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_dat", rdat, 32'd0);

        // first commit: datapath idle, so it lands one cycle after PENDING
        wb_wr(32'h04, 32'd100, 4'hF);
        wb_wr(32'h08, 32'd40, 4'hF);
        wb_wr(32'h00, 32'h11, 4'hF);
        chk("pre_commit_period", 32'(cfg_period), 32'd0);
        wait_cyc(1);
        chk("c1_period", 32'(cfg_period), 32'd100);
        chk("c1_duty0", 32'(cfg_duty[15:0]), 32'd40);
        chk("c1_en", 32'(cfg_en), 32'h1);
        wb_rd(32'h18, q);
        chk("c1_status", q, 32'h4);
        wb_rd(32'h00, q);
        chk("ctrl_readback", q, 32'h10);

        // commit_done interrupt
        wb_wr(32'h1C, 32'h1, 4'hF);
        wait_cyc(1);
        chk("irq_done", 32'(irq), 32'h1);
        wb_wr(32'h18, 32'h4, 4'hF);
        wait_cyc(1);
        chk("irq_done_clr", 32'(irq), 32'h0);

        // clamped duty, waits for period_end since channel 0 is running
        wb_wr(32'h0C, 32'd150, 4'hF);
        wb_wr(32'h00, 32'h11, 4'hF);
        wait_cyc(5);
        chk("wait_duty1", 32'(cfg_duty[31:16]), 32'd0);
        wb_rd(32'h18, q);
        chk("pending_status", q, 32'h1);
        pulse_pe();
        chk("clamp_duty1", 32'(cfg_duty[31:16]), 32'd100);
        chk("keep_duty0", 32'(cfg_duty[15:0]), 32'd40);
        wb_rd(32'h18, q);
        chk("c2_status", q, 32'h4);

        // COMMIT coinciding with period_end: strobe ignored
        wb_wr(32'h10, 32'd7, 4'hF);
        period_end = 1'b1;
        wb_wr(32'h00, 32'h11, 4'hF);
        period_end = 1'b0;
        wait_cyc(3);
        chk("same_cycle_no_commit", 32'(cfg_duty[47:32]), 32'd0);
        wb_wr(32'h10, 32'd9, 4'hF);
        pulse_pe();
        chk("late_shadow_duty2", 32'(cfg_duty[47:32]), 32'd9);

        // fault: one-cycle pulse masks immediately and latches
        @(posedge clk); #1;
        fault = 1'b1;
        #1;
        chk("fault_comb_mask", 32'(cfg_en), 32'h0);
        @(posedge clk); #1;
        fault = 1'b0;
        chk("fault_latched_mask", 32'(cfg_en), 32'h0);
        wb_rd(32'h18, q);
        chk("fault_status", q, 32'h6);
        chk("irq_fault_disabled", 32'(irq), 32'h1);
        wb_wr(32'h1C, 32'h3, 4'hF);
        wait_cyc(1);
        chk("irq_fault_enabled", 32'(irq), 32'h3);
        fault = 1'b1;
        wb_wr(32'h00, 32'h12, 4'hF);
        fault = 1'b0;
        wait_cyc(1);
        chk("fault_clr_ignored", 32'(cfg_en), 32'h0);
        wb_wr(32'h00, 32'h12, 4'hF);
        chk("fault_clr_ok", 32'(cfg_en), 32'h1);
        wait_cyc(1);
        chk("irq_fault_gone", 32'(irq), 32'h1);

        // held fault masks enables, so a commit goes through without period_end
        fault = 1'b1;
        wb_wr(32'h04, 32'd50, 4'hF);
        wb_wr(32'h00, 32'h11, 4'hF);
        wait_cyc(2);
        chk("fault_commit_period", 32'(cfg_period), 32'd50);
        chk("fault_commit_duty1", 32'(cfg_duty[31:16]), 32'd50);
        fault = 1'b0;
        wb_wr(32'h00, 32'h12, 4'hF);

        // out-of-range accesses: no ack, no alias side effect
        ack_cnt = 0;
        @(posedge clk); #1;
        adr = BASE + 32'h44; we = 1'b1; wdat = 32'h1234; sel = 4'hF;
        stb = 1'b1; cyc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ack) ack_cnt++;
        end
        adr = BASE + 32'h40; we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ack) ack_cnt++;
        end
        stb = 1'b0; cyc = 1'b0;
        chk("oor_no_ack", 32'(ack_cnt), 32'd0);
        wb_rd(32'h04, q);
        chk("oor_no_write", q, 32'd50);

        // back-to-back strobe
        @(posedge clk); #1;
        adr = BASE + 32'h04; we = 1'b0; stb = 1'b1; cyc = 1'b1;
        for (int i = 2; i >= 0; i--) begin
            @(posedge clk); #1;
            ack_pat[i] = ack;
        end
        stb = 1'b0; cyc = 1'b0;
        chk("ack_pattern", 32'(ack_pat), 32'h5);

        // byte-lane write
        wb_wr(32'h04, 32'h0000_FFFF, 4'hF);
        wb_wr(32'h04, 32'h0000_ABCD, 4'b0001);
        wb_rd(32'h04, q);
        chk("byte_write", q, 32'h0000_FFCD);

        // asynchronous reset mid-cycle with a commit pending
        wb_wr(32'h00, 32'h11, 4'hF);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst_period", 32'(cfg_period), 32'd0);
        chk("arst_duty", cfg_duty[31:0] | cfg_duty[63:32], 32'd0);
        chk("arst_en", 32'(cfg_en), 32'd0);
        chk("arst_irq", 32'(irq), 32'd0);
        @(negedge clk) rst = 1'b0;
        for (int r = 0; r < 8; r++) begin
            wb_rd(32'(r * 4), q);
            chk($sformatf("arst_reg_%02h", r * 4), q, 32'd0);
        end
        pulse_pe();
        chk("arst_pending_dropped", 32'(cfg_period), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
